// File: rtl/input_loader.sv
// Purpose : UART (8N1, LSB first) image receiver that unpacks each byte into eight 1-bit RAM writes, then kicks the SNN core.
// Latency : ram_we high the 8 cycles after a byte's stop-bit sample; start pulses the cycle after the write to NUM_BITS-1.
// Backpr. : none on rx; after start, bytes are dropped (overrun flagged) until core_done re-arms the loader.
//
// Ports:
//   clk, rst_n      system clock, asynchronous active-low reset
//   rx              UART serial input (idle high, asynchronous to clk)
//   core_done       level from the core; high while waiting re-arms loading
//   ram_addr/_data  1-bit RAM write port (address holds the write pointer when idle)
//   ram_we          RAM write enable
//   start           one-cycle start pulse to the core
//   frame_err       sticky: a stop bit sampled low
//   overrun         sticky: a byte arrived while waiting for the core
module input_loader #(
  parameter int CLKS_PER_BIT = 2604,
  parameter int NUM_BITS     = 784
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rx,
  input  logic       core_done,
  output logic [9:0] ram_addr,
  output logic       ram_data,
  output logic       ram_we,
  output logic       start,
  output logic       frame_err,
  output logic       overrun
);

  localparam int            CW        = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [9:0]    LAST_ADDR = 10'(NUM_BITS - 1);

  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;
  typedef enum logic [1:0] {LD_FILL, LD_WRITE, LD_GO, LD_WAIT} ld_state_t;

  // ---------------------------------------------------------------------------
  // rx synchronizer: both flops reset high so reset does not look like a start bit
  // ---------------------------------------------------------------------------
  logic rx_meta_q, rx_sync_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_meta_q <= 1'b1;
      rx_sync_q <= 1'b1;
    end else begin
      rx_meta_q <= rx;
      rx_sync_q <= rx_meta_q;
    end
  end

  // ---------------------------------------------------------------------------
  // UART receive FSM
  // ---------------------------------------------------------------------------
  rx_state_t     rx_state_q, rx_state_d;
  logic [CW-1:0] clk_cnt_q, clk_cnt_d;
  logic [2:0]    bit_cnt_q, bit_cnt_d;
  logic [7:0]    shift_q, shift_d;
  logic          frame_err_q, frame_err_d;
  logic          byte_valid;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_state_q  <= RX_IDLE;
      clk_cnt_q   <= '0;
      bit_cnt_q   <= '0;
      shift_q     <= '0;
      frame_err_q <= 1'b0;
    end else begin
      rx_state_q  <= rx_state_d;
      clk_cnt_q   <= clk_cnt_d;
      bit_cnt_q   <= bit_cnt_d;
      shift_q     <= shift_d;
      frame_err_q <= frame_err_d;
    end
  end

  always_comb begin
    rx_state_d  = rx_state_q;
    clk_cnt_d   = clk_cnt_q;
    bit_cnt_d   = bit_cnt_q;
    shift_d     = shift_q;
    frame_err_d = frame_err_q;
    byte_valid  = 1'b0;
    case (rx_state_q)
      RX_IDLE: begin
        if (!rx_sync_q) begin
          rx_state_d = RX_START;
          clk_cnt_d  = '0;
          bit_cnt_d  = '0;
        end
      end
      RX_START: begin
        // Re-check mid start bit; a high level here was only a glitch.
        if (clk_cnt_q == HALF_LAST) begin
          clk_cnt_d  = '0;
          rx_state_d = rx_sync_q ? RX_IDLE : RX_DATA;
        end else begin
          clk_cnt_d = clk_cnt_q + 1'b1;
        end
      end
      RX_DATA: begin
        if (clk_cnt_q == BIT_LAST) begin
          clk_cnt_d = '0;
          shift_d   = {rx_sync_q, shift_q[7:1]};
          bit_cnt_d = bit_cnt_q + 1'b1;
          if (bit_cnt_q == 3'd7) rx_state_d = RX_STOP;
        end else begin
          clk_cnt_d = clk_cnt_q + 1'b1;
        end
      end
      RX_STOP: begin
        if (clk_cnt_q == BIT_LAST) begin
          clk_cnt_d  = '0;
          rx_state_d = RX_IDLE;
          if (rx_sync_q) byte_valid  = 1'b1;
          else           frame_err_d = 1'b1;
        end else begin
          clk_cnt_d = clk_cnt_q + 1'b1;
        end
      end
      default: rx_state_d = RX_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Loader FSM: byte -> 8 bit writes, start after the last pixel, wait for core
  // ---------------------------------------------------------------------------
  ld_state_t  ld_state_q, ld_state_d;
  logic [9:0] ptr_q, ptr_d;
  logic [2:0] k_q, k_d;
  logic [7:0] byte_q, byte_d;
  logic       overrun_q, overrun_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ld_state_q <= LD_FILL;
      ptr_q      <= '0;
      k_q        <= '0;
      byte_q     <= '0;
      overrun_q  <= 1'b0;
    end else begin
      ld_state_q <= ld_state_d;
      ptr_q      <= ptr_d;
      k_q        <= k_d;
      byte_q     <= byte_d;
      overrun_q  <= overrun_d;
    end
  end

  always_comb begin
    ld_state_d = ld_state_q;
    ptr_d      = ptr_q;
    k_d        = k_q;
    byte_d     = byte_q;
    overrun_d  = overrun_q;
    ram_addr   = ptr_q;
    ram_data   = 1'b0;
    ram_we     = 1'b0;
    start      = 1'b0;
    case (ld_state_q)
      LD_FILL: begin
        if (byte_valid) begin
          byte_d     = shift_q;
          k_d        = '0;
          ld_state_d = LD_WRITE;
        end
      end
      LD_WRITE: begin
        ram_we   = 1'b1;
        ram_addr = ptr_q + {7'd0, k_q};
        ram_data = byte_q[k_q];
        k_d      = k_q + 1'b1;
        if (k_q == 3'd7) begin
          ptr_d      = ptr_q + 10'd8;
          ld_state_d = (ptr_q + 10'd7 == LAST_ADDR) ? LD_GO : LD_FILL;
        end
      end
      LD_GO: begin
        start      = 1'b1;
        ptr_d      = '0;
        ld_state_d = LD_WAIT;
      end
      LD_WAIT: begin
        // Core still owns the RAM: drop incoming bytes but remember it happened.
        if (byte_valid) overrun_d  = 1'b1;
        if (core_done)  ld_state_d = LD_FILL;
      end
      default: ld_state_d = LD_FILL;
    endcase
  end

  assign frame_err = frame_err_q;
  assign overrun   = overrun_q;

endmodule

// File: tb/tb_input_loader.sv
module tb_input_loader;
  localparam int CPB = 16;
  localparam int NB  = 784;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       rx = 1'b1;
  logic       core_done = 1'b0;
  logic [9:0] ram_addr;
  logic       ram_data, ram_we, start, frame_err, overrun;

  int errors = 0;
  int checks = 0;

  input_loader #(.CLKS_PER_BIT(CPB), .NUM_BITS(NB)) dut (
    .clk(clk), .rst_n(rst_n), .rx(rx), .core_done(core_done),
    .ram_addr(ram_addr), .ram_data(ram_data), .ram_we(ram_we),
    .start(start), .frame_err(frame_err), .overrun(overrun)
  );

  always #5 clk = ~clk;

  // Write / start logger, sampled on the falling edge.
  logic [9:0] addr_log [0:4095];
  logic       data_log [0:4095];
  int         wcyc_log [0:4095];
  int         wr_cnt = 0, start_cnt = 0, start_cyc = 0, cyc = 0, leak_cnt = 0;
  logic [7:0] img [0:127];

  always @(negedge clk) begin
    cyc = cyc + 1;
    if (ram_we === 1'b1) begin
      if (wr_cnt < 4096) begin
        addr_log[wr_cnt] = ram_addr;
        data_log[wr_cnt] = ram_data;
        wcyc_log[wr_cnt] = cyc;
      end
      wr_cnt = wr_cnt + 1;
    end else if (ram_data !== 1'b0) begin
      leak_cnt = leak_cnt + 1;
    end
    if (start === 1'b1) begin
      start_cnt = start_cnt + 1;
      start_cyc = cyc;
    end
  end

  // Counts deviations of a logged write window from img[] written from first_addr,
  // including bytes whose 8 writes are not in consecutive cycles.
  function automatic int window_errs(int base, int first_addr, int nbytes);
    int e = 0;
    for (int i = 0; i < nbytes * 8; i++) begin
      logic [7:0] b;
      b = img[i / 8];
      if (addr_log[base + i] !== 10'(first_addr + i)) e++;
      if (data_log[base + i] !== b[i % 8]) e++;
      if ((i % 8) != 0 && wcyc_log[base + i] != wcyc_log[base + i - 1] + 1) e++;
    end
    return e;
  endfunction

  task automatic idle(int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic bit_out(logic v);
    rx = v;
    repeat (CPB) @(negedge clk);
  endtask

  task automatic send_byte(logic [7:0] b, logic stop_bit);
    bit_out(1'b0);
    for (int i = 0; i < 8; i++) bit_out(b[i]);
    bit_out(stop_bit);
  endtask

  task automatic apply_reset();
    @(negedge clk);
    rx = 1'b1;
    core_done = 1'b0;
    rst_n = 1'b0;
    idle(4);
    rst_n = 1'b1;
    idle(2);
  endtask

  task automatic test_reset();
    int base, sb;
    apply_reset();
    checks++; if (ram_addr !== 10'd0) begin errors++; $display("FAIL reset_addr got=%0d exp=0", ram_addr); end
    checks++; if (ram_we !== 1'b0) begin errors++; $display("FAIL reset_we got=%b exp=0", ram_we); end
    checks++; if (ram_data !== 1'b0) begin errors++; $display("FAIL reset_data got=%b exp=0", ram_data); end
    checks++; if (start !== 1'b0) begin errors++; $display("FAIL reset_start got=%b exp=0", start); end
    checks++; if (frame_err !== 1'b0) begin errors++; $display("FAIL reset_frame_err got=%b exp=0", frame_err); end
    checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL reset_overrun got=%b exp=0", overrun); end
    base = wr_cnt; sb = start_cnt;
    idle(1000);
    checks++; if (wr_cnt - base !== 0) begin errors++; $display("FAIL idle_writes got=%0d exp=0", wr_cnt - base); end
    checks++; if (start_cnt - sb !== 0) begin errors++; $display("FAIL idle_start got=%0d exp=0", start_cnt - sb); end
  endtask

  task automatic test_full_image();
    int base, sb, e;
    base = wr_cnt; sb = start_cnt;
    img[0] = 8'h01;
    for (int i = 1; i < 98; i++) img[i] = 8'hA5;
    for (int i = 0; i < 98; i++) send_byte(img[i], 1'b1);
    idle(40);
    checks++; if (wr_cnt - base !== NB) begin errors++; $display("FAIL full_count got=%0d exp=%0d", wr_cnt - base, NB); end
    e = window_errs(base, 0, 98);
    checks++; if (e !== 0) begin errors++; $display("FAIL full_content bad_writes=%0d exp=0", e); end
    checks++; if (addr_log[base + 8] !== 10'd8 || data_log[base + 8] !== 1'b1 || data_log[base + 9] !== 1'b0)
      begin errors++; $display("FAIL full_addr8 got_addr=%0d d8=%b d9=%b exp=8/1/0", addr_log[base + 8], data_log[base + 8], data_log[base + 9]); end
    checks++; if (start_cnt - sb !== 1) begin errors++; $display("FAIL full_start_pulses got=%0d exp=1", start_cnt - sb); end
    checks++; if (start_cyc !== wcyc_log[base + NB - 1] + 1) begin errors++;
      $display("FAIL full_start_timing got=%0d exp=%0d", start_cyc, wcyc_log[base + NB - 1] + 1); end
    checks++; if (leak_cnt !== 0) begin errors++; $display("FAIL data_idle_zero got=%0d exp=0", leak_cnt); end
  endtask

  task automatic test_overrun_rearm();
    int base, sb, e;
    base = wr_cnt; sb = start_cnt;
    send_byte(8'h3C, 1'b1);
    send_byte(8'hC3, 1'b1);
    idle(40);
    checks++; if (wr_cnt - base !== 0) begin errors++; $display("FAIL wait_writes got=%0d exp=0", wr_cnt - base); end
    checks++; if (overrun !== 1'b1) begin errors++; $display("FAIL overrun_set got=%b exp=1", overrun); end
    core_done = 1'b1;
    idle(1);
    core_done = 1'b0;
    idle(10);
    img[0] = 8'h80;
    base = wr_cnt;
    send_byte(img[0], 1'b1);
    idle(40);
    checks++; if (wr_cnt - base !== 8) begin errors++; $display("FAIL rearm_count got=%0d exp=8", wr_cnt - base); end
    e = window_errs(base, 0, 1);
    checks++; if (e !== 0) begin errors++; $display("FAIL rearm_content bad_writes=%0d exp=0", e); end
    checks++; if (start_cnt - sb !== 0) begin errors++; $display("FAIL rearm_no_start got=%0d exp=0", start_cnt - sb); end
    checks++; if (overrun !== 1'b1) begin errors++; $display("FAIL overrun_sticky got=%b exp=1", overrun); end
  endtask

  task automatic test_frame_err();
    int base, e;
    apply_reset();
    checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL overrun_cleared got=%b exp=0", overrun); end
    base = wr_cnt;
    send_byte(8'hFF, 1'b0);
    bit_out(1'b1);
    bit_out(1'b1);
    checks++; if (frame_err !== 1'b1) begin errors++; $display("FAIL frame_err_set got=%b exp=1", frame_err); end
    checks++; if (wr_cnt - base !== 0) begin errors++; $display("FAIL frame_no_write got=%0d exp=0", wr_cnt - base); end
    img[0] = 8'h0F;
    send_byte(img[0], 1'b1);
    idle(40);
    checks++; if (wr_cnt - base !== 8) begin errors++; $display("FAIL frame_next_count got=%0d exp=8", wr_cnt - base); end
    e = window_errs(base, 0, 1);
    checks++; if (e !== 0) begin errors++; $display("FAIL frame_next_content bad_writes=%0d exp=0", e); end
    checks++; if (frame_err !== 1'b1) begin errors++; $display("FAIL frame_err_sticky got=%b exp=1", frame_err); end
  endtask

  task automatic test_glitch();
    int base, e;
    base = wr_cnt;
    rx = 1'b0;
    idle(5);
    rx = 1'b1;
    idle(100);
    checks++; if (wr_cnt - base !== 0) begin errors++; $display("FAIL glitch_writes got=%0d exp=0", wr_cnt - base); end
    img[0] = 8'h3C;
    send_byte(img[0], 1'b1);
    idle(40);
    checks++; if (wr_cnt - base !== 8) begin errors++; $display("FAIL glitch_next_count got=%0d exp=8", wr_cnt - base); end
    e = window_errs(base, 8, 1);
    checks++; if (e !== 0) begin errors++; $display("FAIL glitch_next_content bad_writes=%0d exp=0", e); end
  endtask

  task automatic test_reset_mid_fill();
    int base, sb, e;
    for (int i = 0; i < 10; i++) send_byte(8'h55, 1'b1);
    bit_out(1'b0);
    bit_out(1'b1);
    bit_out(1'b0);
    rst_n = 1'b0;
    idle(3);
    rx = 1'b1;
    idle(1);
    rst_n = 1'b1;
    idle(50);
    checks++; if (ram_addr !== 10'd0) begin errors++; $display("FAIL midreset_ptr got=%0d exp=0", ram_addr); end
    base = wr_cnt; sb = start_cnt;
    for (int i = 0; i < 98; i++) img[i] = 8'(i * 7 + 3);
    for (int i = 0; i < 98; i++) send_byte(img[i], 1'b1);
    idle(40);
    checks++; if (wr_cnt - base !== NB) begin errors++; $display("FAIL midreset_count got=%0d exp=%0d", wr_cnt - base, NB); end
    e = window_errs(base, 0, 98);
    checks++; if (e !== 0) begin errors++; $display("FAIL midreset_content bad_writes=%0d exp=0", e); end
    checks++; if (start_cnt - sb !== 1) begin errors++; $display("FAIL midreset_start got=%0d exp=1", start_cnt - sb); end
    checks++; if (frame_err !== 1'b0) begin errors++; $display("FAIL midreset_frame_err got=%b exp=0", frame_err); end
  endtask

  initial begin
    test_reset();
    test_full_image();
    test_overrun_rearm();
    test_frame_err();
    test_glitch();
    test_reset_mid_fill();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/input_loader.md
# input_loader

Upstream feeder for the SNN inference path. It receives an image over a UART line (8N1, LSB first) and unpacks each byte into eight 1-bit writes to the 1024x1 input-unit RAM. After the last of the NUM_BITS pixels is written, it pulses start to the core and then holds off further loads until the core reports done. The top level muxes the RAM address: the loader's ram_addr when ram_we is high, otherwise the core's address.

## Interface
- CLKS_PER_BIT, default 2604: clock cycles per UART bit (50 MHz / 19200). Must be ≥ 16.
- NUM_BITS, default 784: pixels per image. Must be a multiple of 8 and ≤ 1024.
- clk  in  1  system clock; all logic on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- rx  in  1  UART serial input, idle high, asynchronous to clk.
- core_done  in  1  done from the SNN core; a high level re-arms the loader.
- ram_addr  out  10  RAM write address (write pointer).
- ram_data  out  1  RAM write data.
- ram_we  out  1  RAM write enable.
- start  out  1  one-cycle start pulse to the core.
- frame_err  out  1  sticky; set when a stop bit samples low.
- overrun  out  1  sticky; set when a byte arrives while waiting for the core.

## Operation
- rx passes through a 2-flop synchronizer. Both flops reset to 1.
- RX FSM:
  - IDLE: on synchronized rx = 0, go to START and clear the bit counter.
  - START: after CLKS_PER_BIT/2 cycles, resample rx. If low, go to DATA. If high, treat as a glitch and return to IDLE.
  - DATA: sample every CLKS_PER_BIT cycles, 8 samples, shifted LSB first. Then go to STOP.
  - STOP: sample after CLKS_PER_BIT cycles.
    - rx high: byte_valid is asserted for 1 cycle.
    - rx low: the byte is discarded and frame_err is set.
    - Either case returns to IDLE.
- Loader FSM:
  - FILL: wait for byte_valid. On byte_valid, latch the byte and go to WRITE.
  - WRITE: 8 consecutive cycles with ram_we = 1, ram_addr = ptr+k and ram_data = byte[k] for k = 0..7. Afterwards ptr += 8.
    - If the write at address NUM_BITS-1 was just done, go to GO.
    - Otherwise return to FILL.
  - GO: start = 1 for exactly one cycle, ptr := 0, go to WAIT.
  - WAIT: every byte_valid is dropped (no writes) and sets overrun. When core_done = 1 is sampled, go to FILL.
- A byte that completes while the loader is in WRITE cannot occur, because CLKS_PER_BIT ≥ 16 gives ≥ 160 cycles per byte.
- ram_addr holds ptr when idle. ram_data is 0 when ram_we = 0.
- frame_err and overrun are cleared only by reset. A frame error does not advance ptr; the next good byte uses the same addresses.

## Timing
- Reset values:
  - ram_addr = 0, ram_data = 0, ram_we = 0, start = 0, frame_err = 0, overrun = 0.
  - Both FSMs in IDLE/FILL, ptr = 0.
- Reset asserted mid-byte, mid-WRITE or in WAIT aborts immediately. The next frame starts at address 0.
- The start-bit falling edge reaches IDLE 2 cycles after it appears on rx (synchronizer).
- byte_valid cycle = T:
  - ram_we is high in cycles T+1..T+8.
  - frame_err is set in cycle T+1 when the stop bit samples low; no byte_valid is asserted in that case.
- The final write (address NUM_BITS-1) occurs in cycle W; start is high in W+1 only.
- core_done sampled high in WAIT: FILL is entered the next cycle. A byte_valid in that same cycle is dropped.
- core_done is ignored in FILL, WRITE and GO.

## Test plan
- Reset: hold rst_n = 0 with rx = 1, then release. All outputs are 0, and no ram_we appears during 1000 idle cycles.
- Full image (CLKS_PER_BIT = 16): send 98 bytes, 0x01 then 0xA5 ×97.
  - Address 0 gets 1 and addresses 1..7 get 0.
  - Address 8 gets 1, then 0,1,0,0,1,0,1.
  - 784 writes total. start is a single pulse 1 cycle after the write to address 783.
- Framing error: send 0xFF with stop bit 0, then 0x0F.
  - No writes for the first byte; frame_err = 1.
  - 0x0F is written to addresses 0..7 as 1,1,1,1,0,0,0,0.
- Glitch: drive rx low for 5 cycles (< 8), then high. No byte_valid, no writes, RX FSM back in IDLE.
- Overrun and re-arm: after start, send 2 bytes. No writes occur and overrun = 1. Pulse core_done for 1 cycle, then send 0x80: address 7 = 1, addresses 0..6 = 0.
- Reset mid-fill: after 10 bytes, pulse rst_n low mid-byte. After release, the next 98 bytes write from address 0, and start pulses once.
